uart_tx_arbiter: RTL and testbench

- Shares one UART transmit engine between 4 byte requesters using a round-robin grant.
- Latches the granted byte and holds the engine start strobe long enough for the slow baud-tick domain to see it.
- Waits for the engine's done flag, then returns a one-cycle completion pulse to the owning requester.
- Sits between the peripheral byte sources and the transmitter. It replaces static config-field channel selection with dynamic fair sharing.

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encoding and default sizes for the UART TX arbiter
package uart_tx_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rtl/uart_tx_arbiter_rr_arbiter.sv - combinational round-robin search: first set req at or above ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_req
);

  logic [PW:0] sum;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      // Wrap by subtraction so non-power-of-two N still works.
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      if (!any_req && req[sum[PW-1:0]]) begin
        any_req = 1'b1;
        grant   = sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmit engine among byte requesters
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int START_HOLD     = 16,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [PW-1:0]             grant_id,
  output logic                      timeout_err,
  input  logic                      clr_err
);

  localparam int HW = $clog2(START_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t        state, state_next;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     arb_grant;
  logic              arb_any;
  logic [HW-1:0]     hold_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              timed_out;
  logic              sync1, sync2, hist;
  logic              done_rise;
  logic              take;
  logic              tmo_hit;
  logic [DATA_W-1:0] win_data;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign done_rise = sync2 & ~hist;
  assign take      = enable & arb_any;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant == PW'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_next = state;
    req_ack    = '0;
    req_done   = '0;
    tx_start   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (take) state_next = START;
      end
      START: begin
        tx_start = 1'b1;
        // hold_cnt is still at its load value only in the first START cycle.
        if (hold_cnt == HW'(START_HOLD - 1)) req_ack[grant_id] = 1'b1;
        if (hold_cnt == '0) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise || tmo_hit) state_next = FINISH;
      end
      FINISH: begin
        if (!timed_out) req_done[grant_id] = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      timed_out   <= 1'b0;
      timeout_err <= 1'b0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      hist        <= 1'b0;
    end else begin
      state <= state_next;
      sync1 <= tx_done;
      sync2 <= sync1;
      hist  <= sync2;

      // A fresh timeout takes precedence over a simultaneous clear.
      if (state == WAIT_DONE && tmo_hit && !done_rise) timeout_err <= 1'b1;
      else if (clr_err)                                timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (take) begin
            grant_id  <= arb_grant;
            tx_data   <= win_data;
            hold_cnt  <= HW'(START_HOLD - 1);
            timed_out <= 1'b0;
          end
        end
        START: begin
          if (hold_cnt == '0) tmo_cnt <= '0;
          else                hold_cnt <= hold_cnt - HW'(1);
        end
        WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (tmo_hit && !done_rise) timed_out <= 1'b1;
        end
        FINISH: begin
          rr_ptr <= (grant_id == PW'(NUM_REQ - 1)) ? '0 : grant_id + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int SH = 16;
  localparam int TO = 100;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ack;
  logic [NR-1:0]   req_done;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_done = 1'b0;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;
  logic            clr_err = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .START_HOLD(SH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .req_done(req_done), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
    .clr_err(clr_err)
  );

  typedef struct {
    logic [3:0] mask;
    logic [1:0] g;
    logic [7:0] d;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] dtab[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic start_phase(input logic [3:0] mask, input logic keep,
                             input logic [1:0] g, input logic [7:0] d);
    int   cnt;
    logic extra_ack;
    req_valid = mask;
    tick;
    check("ack", req_ack, 4'b0001 << g);
    check("grant_id", grant_id, g);
    check("tx_data", tx_data, d);
    check("tx_start_on", tx_start, 1);
    if (!keep) req_valid = '0;
    cnt = 1;
    extra_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (req_ack != 0) extra_ack = 1'b1;
      if (!tx_start) break;
      cnt++;
    end
    check("start_len", cnt, SH);
    check("ack_single", extra_ack, 0);
  endtask

  task automatic done_phase(input logic [1:0] g, input logic [7:0] d);
    int cnt;
    repeat (24) tick;
    tx_done = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      cnt++;
      if (req_done != 0) break;
    end
    check("done_latency", cnt, 3);
    check("req_done", req_done, 4'b0001 << g);
    check("tx_data_hold", tx_data, d);
    tick;
    check("done_single", req_done, 0);
    check("idle_gap", busy, 0);
    tx_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    req_data = {8'hD3, 8'hA5, 8'h3C, 8'h5A};
    dtab[0] = 8'h5A; dtab[1] = 8'h3C; dtab[2] = 8'hA5; dtab[3] = 8'hD3;
    vecs[0] = '{4'b0100, 2'd2, 8'hA5};
    vecs[1] = '{4'b0011, 2'd0, 8'h5A};
    vecs[2] = '{4'b0011, 2'd1, 8'h3C};
    vecs[3] = '{4'b1001, 2'd3, 8'hD3};
    vecs[4] = '{4'b1001, 2'd0, 8'h5A};
    vecs[5] = '{4'b1000, 2'd3, 8'hD3};
    vecs[6] = '{4'b0110, 2'd1, 8'h3C};
    vecs[7] = '{4'b0110, 2'd2, 8'hA5};

    repeat (3) tick;
    check("reset_ctrl", {busy, tx_start, req_ack, req_done, timeout_err}, 0);
    check("reset_data", {grant_id, tx_data}, 0);
    rst = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) begin
      start_phase(vecs[i].mask, 1'b0, vecs[i].g, vecs[i].d);
      done_phase(vecs[i].g, vecs[i].d);
    end

    do_reset;
    for (int k = 0; k < 5; k++) begin
      start_phase(4'b1111, 1'b1, 2'(k % 4), dtab[k % 4]);
      done_phase(2'(k % 4), dtab[k % 4]);
    end
    req_valid = '0;

    do_reset;
    start_phase(4'b0011, 1'b1, 2'd0, 8'h5A);
    done_phase(2'd0, 8'h5A);
    start_phase(4'b0011, 1'b1, 2'd1, 8'h3C);
    done_phase(2'd1, 8'h3C);
    start_phase(4'b0011, 1'b1, 2'd0, 8'h5A);
    done_phase(2'd0, 8'h5A);
    req_valid = '0;

    do_reset;
    enable = 1'b0;
    req_valid = 4'b0100;
    seen = 1'b0;
    repeat (6) begin
      tick;
      if (req_ack != 0 || busy) seen = 1'b1;
    end
    check("enable_block", seen, 0);
    enable = 1'b1;
    start_phase(4'b0100, 1'b0, 2'd2, 8'hA5);
    enable = 1'b0;
    done_phase(2'd2, 8'hA5);
    req_valid = 4'b0001;
    seen = 1'b0;
    repeat (5) begin
      tick;
      if (req_ack != 0 || busy) seen = 1'b1;
    end
    check("enable_hold_idle", seen, 0);
    enable = 1'b1;
    start_phase(4'b0001, 1'b0, 2'd0, 8'h5A);
    done_phase(2'd0, 8'h5A);

    do_reset;
    start_phase(4'b0010, 1'b0, 2'd1, 8'h3C);
    repeat (TO - 1) tick;
    check("tmo_not_yet", {timeout_err, busy}, 2'b01);
    tick;
    check("tmo_set", timeout_err, 1);
    check("tmo_no_done", req_done, 0);
    tick;
    check("tmo_idle", {busy, req_done}, 0);
    check("tmo_sticky", timeout_err, 1);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    check("tmo_clear", timeout_err, 0);

    start_phase(4'b0010, 1'b0, 2'd1, 8'h3C);
    clr_err = 1'b1;
    repeat (TO) tick;
    check("tmo_set_wins", timeout_err, 1);
    tick;
    check("tmo_clr_after", timeout_err, 0);
    clr_err = 1'b0;

    do_reset;
    start_phase(4'b0100, 1'b0, 2'd2, 8'hA5);
    done_phase(2'd2, 8'hA5);
    req_valid = 4'b0010;
    tick;
    check("pre_rst_grant", grant_id, 1);
    req_valid = '0;
    repeat (3) tick;
    #3 rst = 1'b0;
    #1;
    check("async_rst", {tx_start, busy, req_ack, grant_id}, 0);
    tick;
    tick;
    rst = 1'b1;
    start_phase(4'b1010, 1'b0, 2'd1, 8'h3C);
    done_phase(2'd1, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
